// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU and the two-requester ALU arbiter.
//   - ALU_CTRL_W     : width of the one-hot ALU control word
//   - ALU_<op>       : bit position of each operation in the control word
//   - rsp_state_e    : state of the arbiter's one-entry output register
//   - is_onehot()    : legality check for a control word
package alu_pkg;

   localparam int ALU_CTRL_W = 12;

   // Bit positions in the one-hot control word (ALU_ADD = bit 11 = 12'h800).
   localparam int ALU_ADD  = 11;  // src1 + src2
   localparam int ALU_SUB  = 10;  // src1 - src2
   localparam int ALU_SLT  = 9;   // signed   src1 < src2
   localparam int ALU_SLTU = 8;   // unsigned src1 < src2
   localparam int ALU_AND  = 7;
   localparam int ALU_NOR  = 6;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 3;   // src2 << src1[4:0]
   localparam int ALU_SRL  = 2;   // src2 >> src1[4:0]
   localparam int ALU_SRA  = 1;   // src2 >>> src1[4:0]
   localparam int ALU_LUI  = 0;   // {src2[15:0], 16'h0}

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // True when exactly one bit is set: non-zero and clearing the lowest
   // set bit leaves nothing behind.
   function automatic logic is_onehot(input logic [ALU_CTRL_W-1:0] v);
      return (v != '0) && ((v & (v - ALU_CTRL_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/alu.sv
// alu
//   Purely combinational ALU selected by a one-hot control word. Each
//   operation result is gated by its control bit and the gated results are
//   OR-ed together, so a non-one-hot word yields a meaningless mix that the
//   caller must screen out.
// Ports:
//   alu_control  in  ALU_CTRL_W  one-hot operation select
//   alu_src1     in  32          first operand (shift amount for shifts)
//   alu_src2     in  32          second operand (value shifted for shifts)
//   alu_result   out 32          operation result
module alu
   import alu_pkg::*;
(
   input  logic [ALU_CTRL_W-1:0] alu_control,
   input  logic [31:0]           alu_src1,
   input  logic [31:0]           alu_src2,
   output logic [31:0]           alu_result
);

   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic [31:0] slt_res;
   logic [31:0] sltu_res;
   logic [31:0] sll_res;
   logic [31:0] srl_res;
   logic [31:0] sra_res;
   logic [31:0] lui_res;
   logic [4:0]  shamt;

   always_comb begin
      shamt    = alu_src1[4:0];
      add_res  = alu_src1 + alu_src2;
      sub_res  = alu_src1 - alu_src2;
      slt_res  = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
      sltu_res = {31'b0, (alu_src1 < alu_src2)};
      sll_res  = alu_src2 << shamt;
      srl_res  = alu_src2 >> shamt;
      sra_res  = $unsigned($signed(alu_src2) >>> shamt);
      lui_res  = {alu_src2[15:0], 16'h0000};

      alu_result = ({32{alu_control[ALU_ADD ]}} & add_res)
                 | ({32{alu_control[ALU_SUB ]}} & sub_res)
                 | ({32{alu_control[ALU_SLT ]}} & slt_res)
                 | ({32{alu_control[ALU_SLTU]}} & sltu_res)
                 | ({32{alu_control[ALU_AND ]}} & (alu_src1 & alu_src2))
                 | ({32{alu_control[ALU_NOR ]}} & ~(alu_src1 | alu_src2))
                 | ({32{alu_control[ALU_OR  ]}} & (alu_src1 | alu_src2))
                 | ({32{alu_control[ALU_XOR ]}} & (alu_src1 ^ alu_src2))
                 | ({32{alu_control[ALU_SLL ]}} & sll_res)
                 | ({32{alu_control[ALU_SRL ]}} & srl_res)
                 | ({32{alu_control[ALU_SRA ]}} & sra_res)
                 | ({32{alu_control[ALU_LUI ]}} & lui_res);
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters (r0 = execute stage,
//   r1 = secondary issue port) with round-robin priority, screens the control
//   word for one-hot legality and captures {result, id, tag, err} in a
//   one-entry output register.
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   Requesters hold valid and payload until ready; ready may depend on the
//   requester's own valid and on rsp_ready, never the reverse. The response
//   side is the same: a result leaves on an edge with rsp_valid && rsp_ready.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   rX_valid / rX_ready         request handshake for requester X
//   rX_control                  one-hot ALU op select
//   rX_src1, rX_src2            operands
//   rX_tag                      opaque tag returned with the result
//   rsp_valid / rsp_ready       response handshake
//   rsp_result                  ALU result (0 when rsp_err)
//   rsp_id                      winning requester (0 = r0, 1 = r1)
//   rsp_tag                     tag of the winning request
//   rsp_err                     control word was not exactly one-hot
//   dbg_state                   output register FSM state
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic [ALU_CTRL_W-1:0] r0_control,
   input  logic [31:0]           r0_src1,
   input  logic [31:0]           r0_src2,
   input  logic [TAG_W-1:0]      r0_tag,
   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic [ALU_CTRL_W-1:0] r1_control,
   input  logic [31:0]           r1_src1,
   input  logic [31:0]           r1_src2,
   input  logic [TAG_W-1:0]      r1_tag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_result,
   output logic                  rsp_id,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic                  rsp_err,
   output rsp_state_e            dbg_state
);

   rsp_state_e         state_q, state_d;
   logic               prio_q, prio_d;
   logic [31:0]        result_q, result_d;
   logic               id_q, id_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               err_q, err_d;

   logic                  grant0, grant1;
   logic                  can_accept, accept;
   logic                  sel;
   logic [ALU_CTRL_W-1:0] sel_control;
   logic [31:0]           sel_src1, sel_src2;
   logic [TAG_W-1:0]      sel_tag;
   logic                  sel_err;
   logic [31:0]           alu_out;

   // Arbitration: a lone requester always wins; on contention prio_q names
   // the winner. Readys are gated by resetn so nothing is accepted while the
   // block is held in reset.
   always_comb begin
      grant0     = r0_valid && (!r1_valid || (prio_q == 1'b0));
      grant1     = r1_valid && (!r0_valid || (prio_q == 1'b1));
      can_accept = (state_q == RSP_EMPTY) || rsp_ready;
      r0_ready   = resetn && can_accept && grant0;
      r1_ready   = resetn && can_accept && grant1;
      accept     = r0_ready || r1_ready;
   end

   // Operand mux into the shared ALU; r0 is selected when nobody is granted,
   // which is harmless because nothing is loaded then.
   always_comb begin
      sel         = grant1;
      sel_control = sel ? r1_control : r0_control;
      sel_src1    = sel ? r1_src1    : r0_src1;
      sel_src2    = sel ? r1_src2    : r0_src2;
      sel_tag     = sel ? r1_tag     : r0_tag;
      sel_err     = !is_onehot(sel_control);
   end

   alu u_alu (
      .alu_control (sel_control),
      .alu_src1    (sel_src1),
      .alu_src2    (sel_src2),
      .alu_result  (alu_out)
   );

   // Next state: output register FSM, payload and round-robin pointer.
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      result_d = result_q;
      id_d     = id_q;
      tag_d    = tag_q;
      err_d    = err_q;

      case (state_q)
         RSP_EMPTY: if (accept) state_d = RSP_FULL;
         RSP_FULL:  if (rsp_ready && !accept) state_d = RSP_EMPTY;
         default:   state_d = RSP_EMPTY;
      endcase

      if (accept) begin
         result_d = sel_err ? 32'h0 : alu_out;
         id_d     = sel;
         tag_d    = sel_tag;
         err_d    = sel_err;
         // The loser of this transfer gets priority next time.
         prio_d   = ~sel;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= RSP_EMPTY;
         prio_q   <= 1'b0;
         result_q <= 32'h0;
         id_q     <= 1'b0;
         tag_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         result_q <= result_d;
         id_q     <= id_d;
         tag_q    <= tag_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      rsp_valid  = (state_q == RSP_FULL);
      rsp_result = result_q;
      rsp_id     = id_q;
      rsp_tag    = tag_q;
      rsp_err    = err_q;
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int TAG_W = 4;
   localparam int W     = 32 + 1 + TAG_W + 1;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic             r0_valid, r0_ready, r1_valid, r1_ready;
   logic [11:0]      r0_control, r1_control;
   logic [31:0]      r0_src1, r0_src2, r1_src1, r1_src2;
   logic [TAG_W-1:0] r0_tag, r1_tag;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   rsp_state_e       dbg_state;

   alu_arbiter #(.TAG_W(TAG_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .r0_valid   (r0_valid),
      .r0_ready   (r0_ready),
      .r0_control (r0_control),
      .r0_src1    (r0_src1),
      .r0_src2    (r0_src2),
      .r0_tag     (r0_tag),
      .r1_valid   (r1_valid),
      .r1_ready   (r1_ready),
      .r1_control (r1_control),
      .r1_src1    (r1_src1),
      .r1_src2    (r1_src2),
      .r1_tag     (r1_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_id     (rsp_id),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic m_prio;
   logic dut_acc0, dut_acc1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [11:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      case (c)
         12'h800: r = a + b;
         12'h400: r = a - b;
         12'h200: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         12'h100: r = (a < b) ? 32'd1 : 32'd0;
         12'h080: r = a & b;
         12'h040: r = ~(a | b);
         12'h020: r = a | b;
         12'h010: r = a ^ b;
         12'h008: r = b << a[4:0];
         12'h004: r = b >> a[4:0];
         12'h002: r = $unsigned($signed(b) >>> a[4:0]);
         12'h001: r = {b[15:0], 16'h0};
         default: r = 32'h0;  // not one-hot: stored result is zero
      endcase
      return r;
   endfunction

   function automatic logic legal(input logic [11:0] c);
      return $countones(c) == 1;
   endfunction

   function automatic logic [W-1:0] mk_exp(input logic [11:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic id,
                                           input logic [TAG_W-1:0] tag);
      return {alu_model(c, a, b), id, tag, !legal(c)};
   endfunction

   // One clock: at the falling edge check outputs against the model, pop
   // departing results, push accepted requests; then advance past the edge.
   task automatic step();
      logic can, g0, g1;
      logic [W-1:0] e;
      @(negedge clk);
      check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
      can = (exp_q.size() == 0) || rsp_ready;
      g0  = resetn && can && r0_valid && (!r1_valid || !m_prio);
      g1  = resetn && can && r1_valid && (!r0_valid || m_prio);
      check("r0_ready", 64'(r0_ready), 64'(g0));
      check("r1_ready", 64'(r1_ready), 64'(g1));
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("rsp_payload", 64'({rsp_result, rsp_id, rsp_tag, rsp_err}), 64'(e));
      end
      if (g0) exp_q.push_back(mk_exp(r0_control, r0_src1, r0_src2, 1'b0, r0_tag));
      if (g1) exp_q.push_back(mk_exp(r1_control, r1_src1, r1_src2, 1'b1, r1_tag));
      if (g0) m_prio = 1'b1;
      else if (g1) m_prio = 1'b0;
      dut_acc0 = r0_ready;
      dut_acc1 = r1_ready;
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver helpers ----------------
   task automatic set_r0(input logic v, input logic [11:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
      r0_valid = v; r0_control = c; r0_src1 = a; r0_src2 = b; r0_tag = t;
   endtask

   task automatic set_r1(input logic v, input logic [11:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
      r1_valid = v; r1_control = c; r1_src1 = a; r1_src2 = b; r1_tag = t;
   endtask

   function automatic logic [11:0] rand_ctrl();
      logic [11:0] c;
      if ($urandom_range(0, 7) == 0) begin
         c = 12'($urandom);
      end else begin
         c = 12'h001;
         c = c << $urandom_range(0, 11);
      end
      return c;
   endfunction

   task automatic rand_r0();
      set_r0(1'($urandom_range(0, 1)), rand_ctrl(), $urandom, $urandom, TAG_W'($urandom));
   endtask

   task automatic rand_r1();
      set_r1(1'($urandom_range(0, 1)), rand_ctrl(), $urandom, $urandom, TAG_W'($urandom));
   endtask

   task automatic drain();
      r0_valid  = 1'b0;
      r1_valid  = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic             who;
      logic [11:0]      ctrl;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
      logic [31:0]      exp_res;
      logic             exp_err;
   } vec_t;

   vec_t tv[16];
   logic [W-1:0] snap;
   logic         gid[4];

   initial begin
      tv[0]  = '{1'b0, 12'h800, 32'd15,        32'd20,        4'd3, 32'd35,        1'b0};
      tv[1]  = '{1'b1, 12'h400, 32'd5,         32'd7,         4'd1, 32'hFFFF_FFFE, 1'b0};
      tv[2]  = '{1'b0, 12'h200, 32'hFFFF_FFFF, 32'd1,         4'd2, 32'd1,         1'b0};
      tv[3]  = '{1'b1, 12'h100, 32'hFFFF_FFFF, 32'd1,         4'd4, 32'd0,         1'b0};
      tv[4]  = '{1'b0, 12'h080, 32'h0000_F0F0, 32'h0000_FF00, 4'd6, 32'h0000_F000, 1'b0};
      tv[5]  = '{1'b1, 12'h040, 32'h0,         32'h0,         4'd7, 32'hFFFF_FFFF, 1'b0};
      tv[6]  = '{1'b0, 12'h020, 32'h0000_00F0, 32'h0000_000F, 4'd8, 32'h0000_00FF, 1'b0};
      tv[7]  = '{1'b1, 12'h010, 32'h0000_00FF, 32'h0000_000F, 4'd9, 32'h0000_00F0, 1'b0};
      tv[8]  = '{1'b0, 12'h008, 32'd4,         32'd1,         4'hA, 32'd16,        1'b0};
      tv[9]  = '{1'b1, 12'h004, 32'd4,         32'h0000_0100, 4'hB, 32'h0000_0010, 1'b0};
      tv[10] = '{1'b0, 12'h002, 32'd4,         32'h8000_0000, 4'hC, 32'hF800_0000, 1'b0};
      tv[11] = '{1'b1, 12'h001, 32'd0,         32'h0000_1234, 4'hD, 32'h1234_0000, 1'b0};
      tv[12] = '{1'b1, 12'h003, 32'd7,         32'd9,         4'd5, 32'h0,         1'b1};
      tv[13] = '{1'b1, 12'h800, 32'd7,         32'd9,         4'd5, 32'd16,        1'b0};
      tv[14] = '{1'b0, 12'h000, 32'd1,         32'd2,         4'hE, 32'h0,         1'b1};
      tv[15] = '{1'b0, 12'hFFF, 32'd1,         32'd2,         4'hF, 32'h0,         1'b1};

      // ---- reset state (requesters already valid) ----
      resetn    = 1'b0;
      rsp_ready = 1'b1;
      set_r0(1'b1, 12'h800, 32'd1, 32'd2, 4'd1);
      set_r1(1'b1, 12'h800, 32'd3, 32'd4, 4'd2);
      m_prio    = 1'b0;
      #1;
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_r0_ready", 64'(r0_ready), 64'd0);
      check("reset_r1_ready", 64'(r1_ready), 64'd0);
      check("reset_payload", 64'({rsp_result, rsp_id, rsp_tag, rsp_err}), 64'd0);
      check("reset_state", 64'(dbg_state), 64'(RSP_EMPTY));
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;

      // ---- sustained contention: grants r0, r1, r0, r1 ----
      set_r0(1'b1, 12'h800, 32'd100, 32'd1, 4'd1);
      set_r1(1'b1, 12'h010, 32'h55,  32'hF0, 4'd2);
      for (int i = 0; i < 4; i++) begin
         step();
         gid[i] = dut_acc1;
         check("contend_rsp_id", 64'(rsp_id), 64'(i % 2));
         if (dut_acc0) set_r0(1'b1, 12'h800, 32'(200 + i), 32'd3, TAG_W'(i));
         if (dut_acc1) set_r1(1'b1, 12'h020, 32'(300 + i), 32'd5, TAG_W'(i + 8));
      end
      check("contend_grant_seq", 64'({gid[0], gid[1], gid[2], gid[3]}), 64'(4'b0101));
      drain();

      // ---- table-driven single-requester vectors, back to back ----
      for (int i = 0; i < 16; i++) begin
         r0_valid = 1'b0;
         r1_valid = 1'b0;
         if (tv[i].who) set_r1(1'b1, tv[i].ctrl, tv[i].a, tv[i].b, tv[i].tag);
         else           set_r0(1'b1, tv[i].ctrl, tv[i].a, tv[i].b, tv[i].tag);
         rsp_ready = 1'b1;
         step();
         check($sformatf("vec%0d_result", i), 64'(rsp_result), 64'(tv[i].exp_res));
         check($sformatf("vec%0d_err", i), 64'(rsp_err), 64'(tv[i].exp_err));
         check($sformatf("vec%0d_id", i), 64'(rsp_id), 64'(tv[i].who));
         check($sformatf("vec%0d_tag", i), 64'(rsp_tag), 64'(tv[i].tag));
      end
      drain();

      // ---- backpressure: hold 3 cycles with both valid, then pass-through ----
      rsp_ready = 1'b0;
      set_r1(1'b0, 12'h800, 32'd0, 32'd0, 4'd0);
      set_r0(1'b1, 12'h400, 32'd50, 32'd8, 4'd6);
      step();
      snap = {rsp_result, rsp_id, rsp_tag, rsp_err};
      set_r0(1'b1, 12'h800, 32'd11, 32'd22, 4'd7);
      set_r1(1'b1, 12'h080, 32'hFF, 32'h0F, 4'd9);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_stable", 64'({rsp_valid, rsp_result, rsp_id, rsp_tag, rsp_err}),
               64'({1'b1, snap}));
      end
      rsp_ready = 1'b1;
      step();
      check("bp_prio_r1_taken", 64'({dut_acc0, dut_acc1}), 64'(2'b01));
      check("bp_new_result", 64'({rsp_result, rsp_id, rsp_tag}), 64'({32'h0F, 1'b1, 4'd9}));
      r1_valid = 1'b0;
      step();
      drain();

      // ---- reset mid-operation while FULL with prio=1 ----
      rsp_ready = 1'b0;
      set_r0(1'b1, 12'h800, 32'd1, 32'd1, 4'd3);
      r1_valid = 1'b0;
      step();
      r0_valid = 1'b0;
      step();
      check("pre_reset_full", 64'(dbg_state), 64'(RSP_FULL));
      #2;
      resetn = 1'b0;
      #1;
      check("async_reset_valid", 64'(rsp_valid), 64'd0);
      check("async_reset_state", 64'(dbg_state), 64'(RSP_EMPTY));
      exp_q.delete();
      m_prio = 1'b0;
      set_r0(1'b1, 12'h800, 32'd40, 32'd2, 4'd1);
      set_r1(1'b1, 12'h400, 32'd40, 32'd2, 4'd2);
      @(negedge clk);
      check("in_reset_readys", 64'({r0_ready, r1_ready}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn    = 1'b1;
      rsp_ready = 1'b1;
      step();
      check("post_reset_r0_first", 64'({dut_acc0, dut_acc1}), 64'(2'b10));
      r0_valid = 1'b0;
      step();
      drain();

      // ---- random traffic ----
      rand_r0();
      rand_r1();
      for (int i = 0; i < 300; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
         if (!r0_valid || dut_acc0) rand_r0();
         if (!r1_valid || dut_acc1) rand_r1();
      end
      drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters: the execute stage (r0) and a secondary issue port such as an address-generation or branch-compare unit (r1). It arbitrates with round-robin priority. It checks that the ALU control word is legal and captures the result in a one-entry output register with valid/ready backpressure. The result is tagged with the winning requester's id and tag. It sits between the issue logic and writeback, wrapping the existing `alu` instance.

## Interface
Parameters:
- TAG_W, 4, width of the requester-supplied tag returned with each result

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- r0_valid / r1_valid  in  1  requester has an operation
- r0_ready / r1_ready  out  1  operation accepted this cycle (combinational)
- r0_control / r1_control  in  12  one-hot ALU operation select
- r0_src1, r0_src2 / r1_src1, r1_src2  in  32  operands
- r0_tag / r1_tag  in  TAG_W  opaque tag, returned unchanged
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_result  out  32  ALU result (0 on error)
- rsp_id  out  1  0 = r0, 1 = r1
- rsp_tag  out  TAG_W  tag of the granted request
- rsp_err  out  1  control word was not exactly one-hot

## Operation
- Output register FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_ready with no accept.
  - FULL→FULL on rsp_ready with a simultaneous accept (pass-through) or on hold.
- can_accept = EMPTY or rsp_ready.
- Grant rules:
  - One valid requester: that requester is granted.
  - Both valid: requester `prio` is granted.
  - ri_ready = can_accept && grant_i.
  - At most one ri_ready is high per cycle.
  - ri_ready may depend combinationally on ri_valid and rsp_ready. No ready→valid path exists.
- prio register (1 bit): on every accepted transfer, prio becomes the non-granted requester's index. prio is unchanged when no transfer is accepted.
- Granted operands and control are muxed into the `alu`. On accept, the register loads {alu_result, id, tag, err}.
- err = control not exactly one-hot (zero or ≥2 bits set). On error, the stored result is 32'h0.
- While FULL and rsp_ready=0, every rsp_* output stays bit-stable.
- Requesters must hold valid and payload until ready. The block does not check this.

## Timing
- Latency: 1 cycle, accept edge to rsp_valid.
- Throughput: 1 result/cycle under continuous rsp_ready=1.
- Reset values:
  - rsp_valid=0, rsp_result=0, rsp_id=0, rsp_tag=0, rsp_err=0
  - prio=0 (r0 favored first)
  - FSM=EMPTY
- r0_ready/r1_ready are low during reset.
- Reset mid-operation: a held result is discarded. rsp_valid drops asynchronously when resetn falls, with no handshake.
- Simultaneous drain and accept in FULL: the old result leaves and the new result is loaded on the same edge. No bubble.
- Both valid while FULL and rsp_ready=0: no grant, and prio is unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - ALU_CTRL_W=12.
  - Named one-hot bit positions for the twelve ALU operations. ALU_ADD is bit 11, i.e. 12'h800.
  - The onehot-check function, reused by the decoder.
- Sub-module: the existing `alu`, instantiated once, with ports alu_control/alu_src1/alu_src2/alu_result.
- The arbiter, FSM and output register live in `alu_arbiter` itself.

## Test plan
- Single request, legal add: r0 control 12'h800, src1=15, src2=20, tag=3, rsp_ready=1 → next cycle rsp_valid=1, result=35, id=0, tag=3, err=0.
- Sustained contention: r0 and r1 both valid for 4 cycles after reset, rsp_ready=1 → grants r0, r1, r0, r1. rsp_valid stays high on 4 consecutive cycles with rsp_id 0, 1, 0, 1.
- Backpressure: result held, rsp_ready=0 for 3 cycles with both requesters valid → both readys low and rsp_* stable. The cycle rsp_ready rises, the prio requester is accepted and the new result appears on the next edge with no bubble.
- Illegal control: r1 control 12'h003, src 7/9, tag=5 → rsp_err=1, result=0, id=1, tag=5. A following legal add from r1 gives err=0.
- Reset mid-operation: resetn low for 2 cycles while FULL with prio=1 → rsp_valid=0 immediately, without waiting for clk. After release, both valid → r0 granted first.
